// File: rtl/xgmac_rx_frame_buffer.sv
// Store-and-forward RX frame buffer: accepts XGMAC RX beats into a circular RAM and forwards only
// committed good frames to the application. Optional `MAC_FILTER_EN adds destination-MAC filtering.
module xgmac_rx_frame_buffer #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 user_clk,
  input  logic                 reset,
  input  logic [63:0]          axi_str_tdata_from_xgmac,
  input  logic [7:0]           axi_str_tkeep_from_xgmac,
  input  logic                 axi_str_tvalid_from_xgmac,
  input  logic                 axi_str_tlast_from_xgmac,
  input  logic                 axi_str_tuser_from_xgmac,
  output logic [63:0]          axi_str_tdata_to_app,
  output logic [7:0]           axi_str_tkeep_to_app,
  output logic                 axi_str_tvalid_to_app,
  output logic                 axi_str_tlast_to_app,
  input  logic                 axi_str_tready_from_app,
  input  logic [47:0]          mac_id,
  input  logic                 promiscuous_mode_en,
  output logic                 rx_fifo_overflow,
  output logic [CNT_WIDTH-1:0] rx_good_count,
  output logic [CNT_WIDTH-1:0] rx_drop_count
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} wr_state_e;

  localparam ptr_t PTR_ONE   = ptr_t'(1);
  localparam ptr_t FULL_FILL = {1'b1, {ADDR_WIDTH{1'b0}}};

  wr_state_e r_state;
  wr_state_e w_state_nxt;

  ptr_t r_wr_ptr;
  ptr_t r_commit_ptr;
  ptr_t r_rd_ptr;
  ptr_t w_wr_ptr_nxt;
  ptr_t w_commit_nxt;
  ptr_t w_fill;

  logic r_sof;
  logic r_silent;
  logic w_silent_nxt;
  logic w_vld;
  logic w_last;
  logic w_bad;
  logic w_full;
  logic w_accept;
  logic w_wr_en;
  logic w_good_inc;
  logic w_drop_inc;
  logic w_ovf;

  logic [CNT_WIDTH-1:0] r_good_cnt;
  logic [CNT_WIDTH-1:0] r_drop_cnt;
  logic                 r_ovf;

  logic [72:0] r_mem [DEPTH];
  logic [72:0] r_ram_q;
  logic        r_rd_pend;
  logic        r_out_valid;
  logic [72:0] r_out_beat;
  logic        r_skid_valid;
  logic [72:0] r_skid_beat;

  logic       w_rd_avail;
  logic       w_drain;
  logic       w_rd_en;
  logic [1:0] w_occ;

  assign w_vld  = axi_str_tvalid_from_xgmac;
  assign w_last = axi_str_tvalid_from_xgmac & axi_str_tlast_from_xgmac;
  assign w_bad  = axi_str_tuser_from_xgmac;
  assign w_fill = r_wr_ptr - r_rd_ptr;
  assign w_full = (w_fill == FULL_FILL);

`ifdef MAC_FILTER_EN
  logic [47:0] w_dst_mac;
  assign w_dst_mac = axi_str_tdata_from_xgmac[47:0];
  assign w_accept  = (w_dst_mac == mac_id) || (w_dst_mac == '1) || promiscuous_mode_en;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{mac_id, promiscuous_mode_en};
  assign w_accept     = 1'b1;
`endif

  // Write FSM: state register
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_vld) begin
      case (r_state)
        S_IDLE: begin
          if (!w_last) begin
            w_state_nxt = (r_sof && !w_full && w_accept) ? S_RECV : S_DROP;
          end
        end
        S_RECV: begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end else if (w_full) begin
            w_state_nxt = S_DROP;
          end
        end
        S_DROP: begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Write FSM: datapath controls. A tail left over from a reset is dropped silently (no count).
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_good_inc   = 1'b0;
    w_drop_inc   = 1'b0;
    w_ovf        = 1'b0;
    w_silent_nxt = r_silent;
    if (w_vld) begin
      case (r_state)
        S_IDLE, S_RECV: begin
          if (r_state == S_IDLE && !r_sof) begin
            w_silent_nxt = !w_last;
          end else if (w_full) begin
            w_ovf        = 1'b1;
            w_wr_ptr_nxt = r_commit_ptr;
            w_drop_inc   = w_last;
            w_silent_nxt = 1'b0;
          end else if (r_state == S_IDLE && !w_accept) begin
            w_drop_inc   = w_last;
            w_silent_nxt = 1'b0;
          end else begin
            w_wr_en = 1'b1;
            if (w_last && w_bad) begin
              w_wr_ptr_nxt = r_commit_ptr;
              w_drop_inc   = 1'b1;
            end else begin
              w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
              if (w_last) begin
                w_commit_nxt = r_wr_ptr + PTR_ONE;
                w_good_inc   = 1'b1;
              end
            end
          end
        end
        S_DROP: begin
          if (w_last) begin
            w_drop_inc   = !r_silent;
            w_silent_nxt = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Frame-start tracking runs through reset so a frame cut by reset is not taken as a new one.
  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_silent     <= 1'b0;
      r_good_cnt   <= '0;
      r_drop_cnt   <= '0;
      r_ovf        <= 1'b0;
      r_sof        <= !axi_str_tvalid_from_xgmac || axi_str_tlast_from_xgmac;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_silent     <= w_silent_nxt;
      r_ovf        <= w_ovf;
      if (w_good_inc) begin
        r_good_cnt <= r_good_cnt + 1'b1;
      end
      if (w_drop_inc) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      if (w_vld) begin
        r_sof <= axi_str_tlast_from_xgmac;
      end
    end
  end

  // Read side: occupancy includes the in-flight RAM read so out+skid can never overflow.
  assign w_rd_avail = (r_rd_ptr != r_commit_ptr);
  assign w_drain    = r_out_valid & axi_str_tready_from_app;
  assign w_occ      = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_rd_pend} - {1'b0, w_drain};
  assign w_rd_en    = w_rd_avail && (w_occ < 2'd2);

  always_ff @(posedge user_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {axi_str_tlast_from_xgmac, axi_str_tkeep_from_xgmac,
                                          axi_str_tdata_from_xgmac};
    end
    if (w_rd_en) begin
      r_ram_q <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge user_clk) begin
    if (reset) begin
      r_rd_ptr     <= '0;
      r_rd_pend    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_beat   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_beat  <= '0;
    end else begin
      r_rd_pend <= w_rd_en;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (!r_out_valid || w_drain) begin
        if (r_skid_valid) begin
          r_out_beat   <= r_skid_beat;
          r_out_valid  <= 1'b1;
          r_skid_valid <= r_rd_pend;
          if (r_rd_pend) begin
            r_skid_beat <= r_ram_q;
          end
        end else if (r_rd_pend) begin
          r_out_beat  <= r_ram_q;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (r_rd_pend) begin
        r_skid_beat  <= r_ram_q;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign axi_str_tdata_to_app  = r_out_beat[63:0];
  assign axi_str_tkeep_to_app  = r_out_beat[71:64];
  assign axi_str_tlast_to_app  = r_out_beat[72];
  assign axi_str_tvalid_to_app = r_out_valid;
  assign rx_fifo_overflow      = r_ovf;
  assign rx_good_count         = r_good_cnt;
  assign rx_drop_count         = r_drop_cnt;

endmodule

// File: tb/tb_xgmac_rx_frame_buffer.sv
// Directed bench for xgmac_rx_frame_buffer: a default-size instance plus a 16-beat instance for overflow.
module tb_xgmac_rx_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tuser = 1'b0;
  logic [47:0] mac_id = 48'h0A0B0C0D0E0F;
  logic        promisc = 1'b1;
  logic        tready = 1'b0;
  logic        tready_s = 1'b0;
  int          tready_mode = 1;
  int          tready_s_mode = 1;

  logic [63:0] o_tdata, s_tdata;
  logic [7:0]  o_tkeep, s_tkeep;
  logic        o_tvalid, s_tvalid, o_tlast, s_tlast, o_ovf, s_ovf;
  logic [31:0] o_good, o_drop, s_good, s_drop;

  xgmac_rx_frame_buffer #(.ADDR_WIDTH(9), .CNT_WIDTH(32)) dut (
    .user_clk(clk), .reset(rst),
    .axi_str_tdata_from_xgmac(tdata), .axi_str_tkeep_from_xgmac(tkeep),
    .axi_str_tvalid_from_xgmac(tvalid), .axi_str_tlast_from_xgmac(tlast),
    .axi_str_tuser_from_xgmac(tuser),
    .axi_str_tdata_to_app(o_tdata), .axi_str_tkeep_to_app(o_tkeep),
    .axi_str_tvalid_to_app(o_tvalid), .axi_str_tlast_to_app(o_tlast),
    .axi_str_tready_from_app(tready), .mac_id(mac_id), .promiscuous_mode_en(promisc),
    .rx_fifo_overflow(o_ovf), .rx_good_count(o_good), .rx_drop_count(o_drop)
  );

  xgmac_rx_frame_buffer #(.ADDR_WIDTH(4), .CNT_WIDTH(32)) dut_s (
    .user_clk(clk), .reset(rst),
    .axi_str_tdata_from_xgmac(tdata), .axi_str_tkeep_from_xgmac(tkeep),
    .axi_str_tvalid_from_xgmac(tvalid), .axi_str_tlast_from_xgmac(tlast),
    .axi_str_tuser_from_xgmac(tuser),
    .axi_str_tdata_to_app(s_tdata), .axi_str_tkeep_to_app(s_tkeep),
    .axi_str_tvalid_to_app(s_tvalid), .axi_str_tlast_to_app(s_tlast),
    .axi_str_tready_from_app(tready_s), .mac_id(mac_id), .promiscuous_mode_en(promisc),
    .rx_fifo_overflow(s_ovf), .rx_good_count(s_good), .rx_drop_count(s_drop)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int gbase = 0;
  int sbase = 0;
  logic [72:0] exp_q[$];
  logic [72:0] got_q[$];
  logic [72:0] gs_q[$];

  int          rise_cyc = -1;
  logic        prev_v = 1'b0;
  logic        prev_stall = 1'b0;
  logic [72:0] prev_beat = '0;
  int          stall_viol = 0;
  int          ovf_hi = 0;
  int          ovf_hi_s = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    tready   = (tready_mode == 2) ? ($urandom_range(0, 1) == 1) : (tready_mode == 1);
    tready_s = (tready_s_mode == 1);
  end

  always @(negedge clk) begin
    if (o_tvalid && tready) got_q.push_back({o_tlast, o_tkeep, o_tdata});
    if (s_tvalid && tready_s) gs_q.push_back({s_tlast, s_tkeep, s_tdata});
    if (o_tvalid && !prev_v) rise_cyc = cyc;
    prev_v = o_tvalid;
    if (prev_stall && (!o_tvalid || {o_tlast, o_tkeep, o_tdata} !== prev_beat)) stall_viol++;
    prev_stall = o_tvalid && !tready;
    prev_beat  = {o_tlast, o_tkeep, o_tdata};
    if (o_ovf) ovf_hi++;
    if (s_ovf) ovf_hi_s++;
  end

  function automatic logic [63:0] mkdata(input int id, input int b, input logic [47:0] dst);
    logic [63:0] d;
    d[63:48] = {8'(id), 8'(b)};
    d[47:0]  = (b == 0) ? dst : {16'(id * 3 + 1), 16'(b), 16'hBEEF ^ 16'(id)};
    return d;
  endfunction

  task automatic do_reset();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_frame(input int id, input int nb, input bit bad, input logic [47:0] dst,
                            input bit keep_it);
    for (int b = 0; b < nb; b++) begin
      tvalid = 1'b1;
      tdata  = mkdata(id, b, dst);
      tkeep  = (b == nb - 1) ? (8'hFF >> (id % 8)) : 8'hFF;
      tlast  = (b == nb - 1);
      tuser  = (b == nb - 1) && bad;
      if (keep_it) exp_q.push_back({tlast, tkeep, tdata});
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", o_tvalid); end
    n_cmp++; if ({o_tlast, o_tkeep, o_tdata} !== 73'd0) begin n_fail++; $display("FAIL rst_beat: got %h want 0", {o_tlast, o_tkeep, o_tdata}); end
    n_cmp++; if (o_good !== 32'd0) begin n_fail++; $display("FAIL rst_good: got %0d want 0", o_good); end
    n_cmp++; if (o_drop !== 32'd0) begin n_fail++; $display("FAIL rst_drop: got %0d want 0", o_drop); end
    n_cmp++; if (o_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", o_ovf); end
  endtask

  task automatic test_single_frame();
    int commit_cyc;
    int lat;
    do_reset();
    tready_mode = 1; gbase = got_q.size(); exp_q.delete();
    send_frame(1, 8, 1'b0, 48'h0000_1111_2222, 1'b1);
    commit_cyc = cyc;
    repeat (30) @(posedge clk); #1;
    lat = rise_cyc - commit_cyc;
    n_cmp++; if (lat < 1 || lat > 3) begin n_fail++; $display("FAIL single_latency: got %0d cycles want 1..3", lat); end
    n_cmp++; if (got_q.size() - gbase !== 8) begin n_fail++; $display("FAIL single_count: got %0d beats want 8", got_q.size() - gbase); end
    for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[gbase + i] !== exp_q[i]) begin n_fail++; $display("FAIL single_beat%0d: got %h want %h", i, got_q[gbase + i], exp_q[i]); end
    end
    n_cmp++; if (o_good !== 32'd1) begin n_fail++; $display("FAIL single_good: got %0d want 1", o_good); end
    n_cmp++; if (o_drop !== 32'd0) begin n_fail++; $display("FAIL single_drop: got %0d want 0", o_drop); end
  endtask

  task automatic test_back_to_back();
    int ov0;
    do_reset();
    tready_mode = 1; gbase = got_q.size(); exp_q.delete(); ov0 = ovf_hi;
    send_frame(2, 4, 1'b0, 48'h0000_0000_0002, 1'b1);
    send_frame(3, 6, 1'b1, 48'h0000_0000_0003, 1'b0);
    send_frame(4, 3, 1'b0, 48'h0000_0000_0004, 1'b1);
    repeat (40) @(posedge clk); #1;
    n_cmp++; if (got_q.size() - gbase !== 7) begin n_fail++; $display("FAIL b2b_count: got %0d beats want 7", got_q.size() - gbase); end
    for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[gbase + i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_beat%0d: got %h want %h", i, got_q[gbase + i], exp_q[i]); end
    end
    n_cmp++; if (o_good !== 32'd2) begin n_fail++; $display("FAIL b2b_good: got %0d want 2", o_good); end
    n_cmp++; if (o_drop !== 32'd1) begin n_fail++; $display("FAIL b2b_drop: got %0d want 1", o_drop); end
    n_cmp++; if (ovf_hi - ov0 !== 0) begin n_fail++; $display("FAIL b2b_ovf: got %0d pulses want 0", ovf_hi - ov0); end
  endtask

  task automatic test_overflow();
    int ov0;
    do_reset();
    tready_s_mode = 0; tready_mode = 1;
    @(posedge clk); #1;
    sbase = gs_q.size(); exp_q.delete(); ov0 = ovf_hi_s;
    send_frame(5, 10, 1'b0, 48'h0000_0000_0005, 1'b1);
    send_frame(6, 10, 1'b0, 48'h0000_0000_0006, 1'b0);
    repeat (10) @(posedge clk); #1;
    n_cmp++; if (ovf_hi_s - ov0 !== 1) begin n_fail++; $display("FAIL ovf_pulse: got %0d high cycles want 1", ovf_hi_s - ov0); end
    n_cmp++; if (s_drop !== 32'd1) begin n_fail++; $display("FAIL ovf_drop: got %0d want 1", s_drop); end
    n_cmp++; if (s_good !== 32'd1) begin n_fail++; $display("FAIL ovf_good: got %0d want 1", s_good); end
    n_cmp++; if (gs_q.size() - sbase !== 0) begin n_fail++; $display("FAIL ovf_stalled: got %0d beats want 0", gs_q.size() - sbase); end
    tready_s_mode = 1;
    repeat (40) @(posedge clk); #1;
    n_cmp++; if (gs_q.size() - sbase !== 10) begin n_fail++; $display("FAIL ovf_count: got %0d beats want 10", gs_q.size() - sbase); end
    for (int i = 0; i < exp_q.size() && sbase + i < gs_q.size(); i++) begin
      n_cmp++; if (gs_q[sbase + i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_beat%0d: got %h want %h", i, gs_q[sbase + i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    int ov0;
    do_reset();
    tready_mode = 1; gbase = got_q.size(); exp_q.delete(); ov0 = ovf_hi;
    for (int b = 0; b < 8; b++) begin
      tvalid = 1'b1; tdata = mkdata(7, b, 48'h0000_0000_0007); tkeep = 8'hFF;
      tlast = (b == 7); tuser = 1'b0; rst = (b == 3 || b == 4);
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0; rst = 1'b0;
    repeat (30) @(posedge clk); #1;
    n_cmp++; if (got_q.size() - gbase !== 0) begin n_fail++; $display("FAIL midrst_out: got %0d beats want 0", got_q.size() - gbase); end
    n_cmp++; if (o_good !== 32'd0) begin n_fail++; $display("FAIL midrst_good: got %0d want 0", o_good); end
    n_cmp++; if (o_drop !== 32'd0) begin n_fail++; $display("FAIL midrst_drop: got %0d want 0", o_drop); end
    n_cmp++; if (ovf_hi - ov0 !== 0) begin n_fail++; $display("FAIL midrst_ovf: got %0d want 0", ovf_hi - ov0); end
    send_frame(8, 5, 1'b0, 48'h0000_0000_0008, 1'b1);
    repeat (30) @(posedge clk); #1;
    n_cmp++; if (got_q.size() - gbase !== 5) begin n_fail++; $display("FAIL midrst_count: got %0d beats want 5", got_q.size() - gbase); end
    for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[gbase + i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_beat%0d: got %h want %h", i, got_q[gbase + i], exp_q[i]); end
    end
    n_cmp++; if (o_good !== 32'd1) begin n_fail++; $display("FAIL midrst_good2: got %0d want 1", o_good); end
  endtask

  task automatic test_random_stall();
    int sv0;
    int ng;
    int nbad;
    int n;
    bit bad;
    do_reset();
    tready_mode = 2; gbase = got_q.size(); exp_q.delete(); sv0 = stall_viol; ng = 0; nbad = 0;
    for (int f = 0; f < 100; f++) begin
      n = $urandom_range(1, 20);
      bad = ($urandom_range(0, 4) == 0);
      send_frame(100 + f, n, bad, {16'(f), 32'($urandom)}, !bad);
      if (bad) nbad++; else ng++;
      repeat (n + 4) @(posedge clk); #1;
    end
    for (int k = 0; k < 5000 && (got_q.size() - gbase) < exp_q.size(); k++) begin
      @(posedge clk); #1;
    end
    tready_mode = 1;
    n_cmp++; if (got_q.size() - gbase !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d beats want %0d", got_q.size() - gbase, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[gbase + i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_beat%0d: got %h want %h", i, got_q[gbase + i], exp_q[i]); end
    end
    n_cmp++; if (o_good !== 32'(ng)) begin n_fail++; $display("FAIL rand_good: got %0d want %0d", o_good, ng); end
    n_cmp++; if (o_drop !== 32'(nbad)) begin n_fail++; $display("FAIL rand_drop: got %0d want %0d", o_drop, nbad); end
    n_cmp++; if (stall_viol - sv0 !== 0) begin n_fail++; $display("FAIL rand_stall_stable: got %0d violations want 0", stall_viol - sv0); end
  endtask

`ifdef MAC_FILTER_EN
  task automatic test_mac_filter();
    do_reset();
    tready_mode = 1; gbase = got_q.size(); exp_q.delete();
    promisc = 1'b0; mac_id = 48'h0A0B0C0D0E0F;
    send_frame(20, 3, 1'b0, 48'h0A0B0C0D0E0F, 1'b1);
    send_frame(21, 3, 1'b0, 48'hFFFFFFFFFFFF, 1'b1);
    send_frame(22, 3, 1'b0, 48'h112233445566, 1'b0);
    promisc = 1'b1;
    send_frame(23, 3, 1'b0, 48'h112233445566, 1'b1);
    repeat (40) @(posedge clk); #1;
    n_cmp++; if (got_q.size() - gbase !== 9) begin n_fail++; $display("FAIL mac_count: got %0d beats want 9", got_q.size() - gbase); end
    for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[gbase + i] !== exp_q[i]) begin n_fail++; $display("FAIL mac_beat%0d: got %h want %h", i, got_q[gbase + i], exp_q[i]); end
    end
    n_cmp++; if (o_good !== 32'd3) begin n_fail++; $display("FAIL mac_good: got %0d want 3", o_good); end
    n_cmp++; if (o_drop !== 32'd1) begin n_fail++; $display("FAIL mac_drop: got %0d want 1", o_drop); end
  endtask
`else
  task automatic test_mac_ignored();
    do_reset();
    tready_mode = 1; gbase = got_q.size(); exp_q.delete();
    promisc = 1'b0; mac_id = 48'h0A0B0C0D0E0F;
    send_frame(24, 3, 1'b0, 48'h112233445566, 1'b1);
    repeat (30) @(posedge clk); #1;
    promisc = 1'b1;
    n_cmp++; if (got_q.size() - gbase !== 3) begin n_fail++; $display("FAIL macign_count: got %0d beats want 3", got_q.size() - gbase); end
    for (int i = 0; i < exp_q.size() && gbase + i < got_q.size(); i++) begin
      n_cmp++; if (got_q[gbase + i] !== exp_q[i]) begin n_fail++; $display("FAIL macign_beat%0d: got %h want %h", i, got_q[gbase + i], exp_q[i]); end
    end
    n_cmp++; if (o_good !== 32'd1) begin n_fail++; $display("FAIL macign_good: got %0d want 1", o_good); end
    n_cmp++; if (o_drop !== 32'd0) begin n_fail++; $display("FAIL macign_drop: got %0d want 0", o_drop); end
  endtask
`endif

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_random_stall();
`ifdef MAC_FILTER_EN
    test_mac_filter();
`else
    test_mac_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
